// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC and the IF_ID pipeline register, drives a
// request/ready instruction-memory port with arbitrary fetch latency, and applies
// decode-stage redirects, stalls and flushes.
//
// Optional build macro: IF_PERF_CNT_EN
//   When defined, adds fetch_cnt (instructions delivered into IF_ID) and
//   flush_cnt (cycles with an active redirect). Both clear on rst and wrap.
//
// IF_ID layout: [63:32] = PC+4 of the instruction, [31:0] = instruction.
// Every NOP bubble carries (PC after that edge) + 4 so an interrupt taken on a
// bubble still records a correct return address.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000,
    parameter logic [31:0] INT_PC   = 32'h8000_0004,
    parameter logic [31:0] EXC_PC   = 32'h8000_0008,
    parameter logic [31:0] NOP      = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        PC_IF_ID_Write,
    input  logic        Z,
    input  logic        J,
    input  logic        JR,
    input  logic        interrupt,
    input  logic        exception,
    input  logic [31:0] branch_target,
    input  logic [31:0] jump_target,
    input  logic [31:0] jr_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ready,
    output logic [63:0] IF_ID,
    output logic [31:0] PC
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0] fetch_cnt,
    output logic [31:0] flush_cnt
`endif
);

    // FETCH   : request outstanding at PC.
    // DISCARD : a wrong-path request is still outstanding; its data is dropped.
    // HOLD    : an instruction arrived during a stall and waits in buf.
    typedef enum logic [1:0] {
        S_FETCH   = 2'd0,
        S_DISCARD = 2'd1,
        S_HOLD    = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [63:0] if_id_q, if_id_d;
    logic [31:0] buf_q, buf_d;          // instruction captured while stalled
    logic [31:0] pend_q, pend_d;        // redirect target waiting for stale data
    logic [31:0] stale_addr_q, stale_addr_d; // address of the abandoned request

    logic        stall;
    logic        redir;
    logic [31:0] redir_target;
    logic [31:0] redir_plus4;
    logic [31:0] pc_plus4;

    // Redirect decode: exception and interrupt override a stall, control-flow
    // redirects from decode are only honoured when decode is advancing.
    always_comb begin
        stall = ~PC_IF_ID_Write;
        redir = exception | interrupt | (~stall & (J | JR | Z));
        if (exception) begin
            redir_target = EXC_PC;
        end else if (interrupt) begin
            redir_target = INT_PC;
        end else if (JR) begin
            redir_target = jr_target;
        end else if (J) begin
            redir_target = jump_target;
        end else begin
            redir_target = branch_target;
        end
        redir_plus4 = redir_target + 32'd4;
        pc_plus4    = pc_q + 32'd4;
    end

    // Next-state and datapath update for the fetch FSM.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        if_id_d      = if_id_q;
        buf_d        = buf_q;
        pend_d       = pend_q;
        stale_addr_d = stale_addr_q;

        case (state_q)
            S_FETCH: begin
                if (redir) begin
                    // Redirect wins over any data returning this cycle.
                    pc_d    = redir_target;
                    if_id_d = {redir_plus4, NOP};
                    if (!imem_ready) begin
                        // Request must run to completion at its original address.
                        pend_d       = redir_target;
                        stale_addr_d = pc_q;
                        state_d      = S_DISCARD;
                    end
                end else if (imem_ready && !stall) begin
                    if_id_d = {pc_plus4, imem_rdata};
                    pc_d    = pc_plus4;
                end else if (imem_ready) begin
                    buf_d   = imem_rdata;
                    state_d = S_HOLD;
                end else if (!stall) begin
                    if_id_d = {pc_plus4, NOP};
                end
            end

            S_DISCARD: begin
                if (redir) begin
                    pend_d = redir_target;
                end
                if (imem_ready) begin
                    state_d = S_FETCH;
                end
                // PC tracks the pending target so the resumed fetch starts there.
                pc_d = pend_d;
                if (redir || !stall) begin
                    if_id_d = {pend_d + 32'd4, NOP};
                end
            end

            S_HOLD: begin
                if (redir) begin
                    pc_d    = redir_target;
                    if_id_d = {redir_plus4, NOP};
                    state_d = S_FETCH;
                end else if (!stall) begin
                    if_id_d = {pc_plus4, buf_q};
                    pc_d    = pc_plus4;
                    state_d = S_FETCH;
                end
            end

            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    // State register; reset abandons any outstanding request.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_FETCH;
            pc_q         <= RESET_PC;
            if_id_q      <= {RESET_PC + 32'd4, NOP};
            buf_q        <= 32'd0;
            pend_q       <= 32'd0;
            stale_addr_q <= 32'd0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            if_id_q      <= if_id_d;
            buf_q        <= buf_d;
            pend_q       <= pend_d;
            stale_addr_q <= stale_addr_d;
        end
    end

    // Memory port and pipeline outputs derive from registered state only.
    always_comb begin
        imem_req  = (state_q != S_HOLD);
        imem_addr = (state_q == S_DISCARD) ? stale_addr_q : pc_q;
        PC        = (state_q == S_DISCARD) ? pend_q : pc_q;
        IF_ID     = if_id_q;
    end

`ifdef IF_PERF_CNT_EN
    logic        deliver;
    logic [31:0] fetch_cnt_q, fetch_cnt_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;

    // A real instruction enters IF_ID from the memory or from the hold buffer.
    always_comb begin
        deliver = ~redir & ~stall &
                  (((state_q == S_FETCH) & imem_ready) | (state_q == S_HOLD));
        fetch_cnt_d = fetch_cnt_q + (deliver ? 32'd1 : 32'd0);
        flush_cnt_d = flush_cnt_q + (redir ? 32'd1 : 32'd0);
    end

    // Performance counters, free-running with wraparound.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_cnt_q <= 32'd0;
            flush_cnt_q <= 32'd0;
        end else begin
            fetch_cnt_q <= fetch_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign fetch_cnt = fetch_cnt_q;
    assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_if_stage.sv
// Testbench for if_stage: directed scenarios followed by randomized traffic.
// A driver applies inputs on the falling edge, advances a behavioural model and
// queues the expected post-edge outputs; a monitor pops and compares after each
// rising edge.
module tb_if_stage;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic        wr = 1'b1;
    logic        z = 1'b0, j = 1'b0, jr = 1'b0, intr = 1'b0, exc = 1'b0;
    logic [31:0] bt = '0, jt = '0, jrt = '0;
    logic [31:0] rdata = '0;
    logic        ready = 1'b0;
    logic        req;
    logic [31:0] addr;
    logic [31:0] pc;
    logic [63:0] ifid;
`ifdef IF_PERF_CNT_EN
    logic [31:0] fcnt, xcnt;
`endif

    if_stage dut (
        .clk           (clk),
        .rst           (rst),
        .PC_IF_ID_Write(wr),
        .Z             (z),
        .J             (j),
        .JR            (jr),
        .interrupt     (intr),
        .exception     (exc),
        .branch_target (bt),
        .jump_target   (jt),
        .jr_target     (jrt),
        .imem_req      (req),
        .imem_addr     (addr),
        .imem_rdata    (rdata),
        .imem_ready    (ready),
        .IF_ID         (ifid),
        .PC            (pc)
`ifdef IF_PERF_CNT_EN
        ,
        .fetch_cnt     (fcnt),
        .flush_cnt     (xcnt)
`endif
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [63:0] ifid;
        logic        req;
        logic [31:0] addr;
        logic [31:0] fc;
        logic [31:0] xc;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_steps = 0;

    // Behavioural model: the PC, the pipeline register, an optional abandoned
    // request (address kept until memory answers) and a list of instructions
    // parked while decode was stalled.
    logic [31:0] m_pc;
    logic [63:0] m_ifid;
    bit          m_stale;
    logic [31:0] m_stale_addr;
    logic [31:0] m_parked[$];
    logic [31:0] m_fc, m_xc;
    logic [31:0] salt = 32'd0;

    function automatic logic [31:0] mem_word(input logic [31:0] a, input logic [31:0] s);
        return a ^ s;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s step=%0d actual=%h required=%h", name, n_steps, act, expv);
        end
    endtask

    // One clock of stimulus plus the model's view of what follows the edge.
    task automatic step(input bit r, input bit w, input bit zz, input bit jj, input bit jjr,
                        input bit ii, input bit ee, input logic [31:0] b,
                        input logic [31:0] jtv, input logic [31:0] jrtv, input bit rdy);
        logic [31:0] cur_addr;
        bit          cur_req, redirect, stalled;
        logic [31:0] tgt;
        exp_t        e;
        @(negedge clk);
        cur_req  = (m_parked.size() == 0);
        cur_addr = m_stale ? m_stale_addr : m_pc;
        rst = r; wr = w; z = zz; j = jj; jr = jjr; intr = ii; exc = ee;
        bt = b; jt = jtv; jrt = jrtv;
        ready = rdy & cur_req;
        rdata = ready ? mem_word(cur_addr, salt) : $urandom;

        stalled  = !w;
        redirect = ee || ii || (!stalled && (zz || jj || jjr));
        tgt = ee ? 32'h8000_0008 : ii ? 32'h8000_0004 : jjr ? jrtv : jj ? jtv : b;

        if (r) begin
            m_pc = 32'h8000_0000;
            m_ifid = {32'h8000_0004, 32'h0};
            m_stale = 0;
            m_parked.delete();
            m_fc = 0;
            m_xc = 0;
        end else begin
            if (redirect) m_xc = m_xc + 1;
            if (m_parked.size() != 0) begin
                if (redirect) begin
                    m_parked.delete();
                    m_pc = tgt;
                    m_ifid = {tgt + 32'd4, 32'h0};
                end else if (!stalled) begin
                    m_ifid = {m_pc + 32'd4, m_parked.pop_front()};
                    m_pc = m_pc + 32'd4;
                    m_fc = m_fc + 1;
                end
            end else if (m_stale) begin
                if (redirect) m_pc = tgt;
                if (ready) m_stale = 0;
                if (redirect || !stalled) m_ifid = {m_pc + 32'd4, 32'h0};
            end else begin
                if (redirect) begin
                    if (!ready) begin
                        m_stale = 1;
                        m_stale_addr = m_pc;
                    end
                    m_pc = tgt;
                    m_ifid = {tgt + 32'd4, 32'h0};
                end else if (ready && stalled) begin
                    m_parked.push_back(rdata);
                end else if (ready) begin
                    m_ifid = {m_pc + 32'd4, rdata};
                    m_pc = m_pc + 32'd4;
                    m_fc = m_fc + 1;
                end else if (!stalled) begin
                    m_ifid = {m_pc + 32'd4, 32'h0};
                end
            end
        end
        e.pc   = m_pc;
        e.ifid = m_ifid;
        e.req  = (m_parked.size() == 0);
        e.addr = m_stale ? m_stale_addr : m_pc;
        e.fc   = m_fc;
        e.xc   = m_xc;
        exp_q.push_back(e);
    endtask

    // Monitor: compare DUT outputs against the oldest queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_steps++;
                chk("pc", {32'd0, pc}, {32'd0, e.pc});
                chk("if_id", ifid, e.ifid);
                chk("imem_req", {63'd0, req}, {63'd0, e.req});
                chk("imem_addr", {32'd0, addr}, {32'd0, e.addr});
`ifdef IF_PERF_CNT_EN
                chk("fetch_cnt", {32'd0, fcnt}, {32'd0, e.fc});
                chk("flush_cnt", {32'd0, xcnt}, {32'd0, e.xc});
`endif
                $display("[TB] step %0d pc=%h if_id=%h req=%0b addr=%h", n_steps, pc, ifid, req, addr);
            end
        end
    end

    // Driver: directed scenarios, then randomized traffic.
    initial begin
        int waited;
        m_pc = 32'h8000_0000; m_ifid = {32'h8000_0004, 32'h0};
        m_stale = 0; m_stale_addr = 0; m_fc = 0; m_xc = 0;

        // Reset, then zero-wait sequential fetch with data equal to address.
        step(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 4; i++) step(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        // Taken branch with zero-wait memory.
        step(0, 1, 1, 0, 0, 0, 0, 32'h8000_0100, 0, 0, 1);
        step(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        salt = 32'h5A5A_1234;
        // 3-cycle latency with a jump in the first wait cycle.
        step(0, 1, 0, 1, 0, 0, 0, 0, 32'h0040_0000, 0, 0);
        step(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        step(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        // Data returns under a two-cycle stall, then release.
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        step(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        // Stalled branch is ignored; stalled interrupt is taken.
        step(0, 0, 1, 0, 0, 0, 0, 32'h1234_0000, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        // Exception and interrupt together.
        step(0, 1, 0, 0, 0, 1, 1, 0, 0, 0, 1);
        // Enter DISCARD, then reset mid-request.
        step(0, 1, 0, 0, 1, 0, 0, 0, 0, 32'hFFFF_FFFC, 0);
        step(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        // PC+4 wraparound.
        step(0, 1, 0, 1, 0, 0, 0, 0, 32'hFFFF_FFFC, 0, 1);
        step(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        step(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1);

        // Randomized traffic.
        salt = $urandom;
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 99) == 0,
                 $urandom_range(0, 99) >= 25,
                 $urandom_range(0, 99) < 15,
                 $urandom_range(0, 99) < 8,
                 $urandom_range(0, 99) < 8,
                 $urandom_range(0, 99) < 3,
                 $urandom_range(0, 99) < 3,
                 $urandom & 32'hFFFF_FFFC,
                 $urandom & 32'hFFFF_FFFC,
                 $urandom & 32'hFFFF_FFFC,
                 $urandom_range(0, 99) < 50);
        end

        waited = 0;
        while (exp_q.size() > 0 && waited < 10) begin
            @(posedge clk);
            waited++;
        end
        #2;
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain actual=%0d required=0 pending expectations", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage; sits directly upstream of the decode stage.
- Owns the PC and the IF_ID pipeline register: IF_ID[31:0] holds the instruction, IF_ID[63:32] holds PC+4.
- Drives a request/ready instruction-memory port that supports multi-cycle fetch latency.
- Applies decode-stage redirects (branch, J, JR, interrupt, exception), stalls and flushes. Wrong-path fetches are dropped without breaking the memory handshake.

Parameters:
- RESET_PC, 32'h8000_0000, PC value after reset.
- INT_PC, 32'h8000_0004, interrupt vector.
- EXC_PC, 32'h8000_0008, undefined-instruction exception vector.
- NOP, 32'h0000_0000, instruction inserted for bubbles and flushes.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous reset, active-high.
- PC_IF_ID_Write  in  1  0 = decode stall; hold PC and IF_ID.
- Z  in  1  taken conditional branch.
- J  in  1  jump.
- JR  in  1  jump register.
- interrupt  in  1  take interrupt.
- exception  in  1  undefined instruction.
- branch_target  in  32  redirect address for Z.
- jump_target  in  32  redirect address for J.
- jr_target  in  32  redirect address for JR.
- imem_req  out  1  fetch request.
- imem_addr  out  32  fetch address; word aligned.
- imem_rdata  in  32  fetched instruction; valid when imem_ready=1.
- imem_ready  in  1  completes the outstanding request this cycle.
- IF_ID  out  64  {PC+4, instruction} to decode.
- PC  out  32  current fetch PC.

Behaviour:
- Reset (synchronous, active-high): PC=RESET_PC; IF_ID={RESET_PC+4, NOP}; state=FETCH; holding buffer and pending target cleared.
- stall = ~PC_IF_ID_Write.
- Redirect target, in priority order:
  - exception → EXC_PC
  - interrupt → INT_PC
  - JR → jr_target
  - J → jump_target
  - Z → branch_target
- Redirect conditions:
  - exception and interrupt always take effect, even during stall.
  - J, JR and Z are ignored while stall=1.
  - redir = exception | interrupt | (~stall & (J | JR | Z)).
- Bubble rule: every NOP written into IF_ID carries PC+4 = (PC value after that edge) + 4. This keeps the interrupt return address correct.
- Handshake:
  - imem_addr is held stable from request until imem_ready.
  - Zero-wait memory (imem_ready=1 in the same cycle) yields one instruction per cycle.
- State FETCH (imem_req=1, imem_addr=PC):
  - redir: PC←target, IF_ID←NOP. If imem_ready=1, rdata is dropped and state stays FETCH; otherwise pend←target and state→DISCARD.
  - else imem_ready & ~stall: IF_ID←{PC+4, rdata}, PC←PC+4.
  - else imem_ready & stall: buf←rdata; state→HOLD; PC and IF_ID held.
  - else ~imem_ready & ~stall: IF_ID←NOP bubble.
  - else (~imem_ready & stall): hold.
- State DISCARD (imem_req=1, imem_addr = stale address latched on entry):
  - A further redir updates pend and writes a NOP.
  - On imem_ready: rdata dropped; PC←pend; state→FETCH.
  - While in DISCARD, IF_ID receives a NOP whenever ~stall.
  - PC output shows pend.
- State HOLD (imem_req=0):
  - redir: buf dropped; PC←target; IF_ID←NOP; state→FETCH.
  - ~stall: IF_ID←{PC+4, buf}; PC←PC+4; state→FETCH.
  - stall: hold.
- Arithmetic: PC+4 is a 32-bit wraparound add. PC[31] follows the target as given; no masking.
- Simultaneous redir and imem_ready in FETCH: the redirect wins and rdata is discarded.
- Reset asserted mid-request: state returns to FETCH at RESET_PC immediately. The memory must tolerate an abandoned request.

Optional Feature:
- Macro IF_PERF_CNT_EN.
- When defined, adds output ports fetch_cnt[31:0] and flush_cnt[31:0]:
  - fetch_cnt increments on each instruction delivered into IF_ID.
  - flush_cnt increments on each cycle with redir=1.
  - Both counters clear on rst and wrap at 2^32.
- When undefined, these ports and the counters do not exist; all other behaviour is identical.

Test Plan:
- Reset release with zero-wait memory returning {addr} as data → IF_ID sequence {0x8000_0004, 0x8000_0000}, {0x8000_0008, 0x8000_0004}, one per cycle; imem_addr increments by 4.
- Z=1 with branch_target=0x8000_0100 while FETCH, ready=1 → IF_ID={0x8000_0104, NOP}; next imem_addr=0x8000_0100.
- 3-cycle memory latency and J=1 (target 0x0040_0000) in the first wait cycle → imem_addr stays on the stale address until ready; rdata dropped; then imem_addr=0x0040_0000; NOPs in IF_ID meanwhile.
- PC_IF_ID_Write=0 for 2 cycles while data returns → state HOLD, imem_req=0, IF_ID unchanged; on release IF_ID holds the buffered instruction.
- Stall with Z=1 → no redirect; stall with interrupt=1 → PC=0x8000_0004, IF_ID={0x8000_0008, NOP}.
- exception and interrupt together → PC=0x8000_0008. rst asserted during DISCARD → PC=0x8000_0000 next cycle; state FETCH.
